sreg_serializer: RTL and testbench

Byte-to-serial marshalling shift register: accepts parallel bytes over a valid/ready handshake and shifts them out LSB first, one bit per clock. It is the transmit counterpart of `sreg_marshalling`: its `serial_out` feeds that block's `serial_in` directly. A one-entry holding buffer lets back-to-back bytes stream with no idle bit-times between them.

---
 rtl/marshalling_pkg.sv | 6 +
 rtl/sreg_serializer.sv | 99 +++++++++
 tb/tb_sreg_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/marshalling_pkg.sv
// Shared definitions for the marshalling serializer/deserializer pair.
package marshalling_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {IDLE, SHIFT} ser_state_t;
endpackage

// File: rtl/sreg_serializer.sv
// Parallel-to-serial shift register, LSB first, with a one-word holding buffer
// so that consecutive words stream without idle bit-times.
module sreg_serializer
  import marshalling_pkg::*;
#(
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              serial_out,
  output logic              serial_valid,
  output logic              byte_done,
  output logic              busy
);

  localparam int                CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  ser_state_t        state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic              hold_full_reg, hold_full_next;
  logic [CNT_W-1:0]  bitcnt_reg, bitcnt_next;

  logic xfer;
  logic last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      bitcnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      bitcnt_reg    <= bitcnt_next;
    end
  end

  always_comb begin
    byte_ready = !hold_full_reg && !rst;
    xfer       = byte_valid && !hold_full_reg && !rst;
    last_bit   = (state_reg == SHIFT) && (bitcnt_reg == LAST);
  end

  // Next-word selection: a held word wins over a fresh one at the last bit.
  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    bitcnt_next    = bitcnt_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          shreg_next  = byte_in;
          bitcnt_next = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_next  = shreg_reg >> 1;
          bitcnt_next = bitcnt_reg + CNT_W'(1);
          if (xfer) begin
            hold_next      = byte_in;
            hold_full_next = 1'b1;
          end
        end else if (hold_full_reg) begin
          shreg_next     = hold_reg;
          hold_full_next = 1'b0;
          bitcnt_next    = '0;
        end else if (xfer) begin
          shreg_next  = byte_in;
          bitcnt_next = '0;
        end else begin
          bitcnt_next = '0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    serial_valid = (state_reg == SHIFT);
    serial_out   = serial_valid && shreg_reg[0];
    byte_done    = last_bit;
    busy         = (state_reg == SHIFT) || hold_full_reg;
  end

endmodule

// File: tb/tb_sreg_serializer.sv
// Bench for sreg_serializer: a queue-of-words model checked every cycle,
// plus directed scenarios with hand-computed expectations and random traffic.
module tb_sreg_serializer;
  localparam int W = 8;
  localparam int LOG_N = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_ready, serial_out, serial_valid, byte_done, busy;

  always #5 clk = ~clk;

  sreg_serializer #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .serial_out(serial_out),
    .serial_valid(serial_valid), .byte_done(byte_done), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;
  int edge_cnt = 0;

  // Model: words in flight (front is being shifted), and bit position within the front word.
  logic [W-1:0] mq[$];
  int           pos = 0;
  bit           m_xfer;
  logic [W-1:0] m_front;
  logic         e_valid, e_bit, e_done, e_busy, e_ready;

  logic lv[LOG_N], lb[LOG_N], ld[LOG_N], lr[LOG_N], lbusy[LOG_N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_xfer = !rst && byte_valid && (mq.size() < 2);
    edge_cnt++;
    if (rst) begin
      mq.delete();
      pos = 0;
    end else begin
      if (mq.size() > 0) begin
        if (pos == W - 1) begin
          void'(mq.pop_front());
          pos = 0;
        end else begin
          pos++;
        end
      end
      if (m_xfer) mq.push_back(byte_in);
    end
  end

  always @(negedge clk) begin
    e_valid = mq.size() > 0;
    m_front = e_valid ? mq[0] : '0;
    e_bit   = e_valid ? m_front[pos] : 1'b0;
    e_done  = e_valid && (pos == W - 1);
    e_busy  = e_valid;
    e_ready = !rst && (mq.size() < 2);
    if (checking) begin
      chk($sformatf("serial_valid@%0d", edge_cnt), serial_valid, e_valid);
      chk($sformatf("serial_out@%0d", edge_cnt), serial_out, e_bit);
      chk($sformatf("byte_done@%0d", edge_cnt), byte_done, e_done);
      chk($sformatf("busy@%0d", edge_cnt), busy, e_busy);
      chk($sformatf("byte_ready@%0d", edge_cnt), byte_ready, e_ready);
    end
    if (edge_cnt < LOG_N) begin
      lv[edge_cnt] = serial_valid;
      lb[edge_cnt] = serial_out;
      ld[edge_cnt] = byte_done;
      lr[edge_cnt] = byte_ready;
      lbusy[edge_cnt] = busy;
    end
  end

  // Returns the cycle in which the word was accepted (it shifts from the next cycle).
  task automatic send(input logic [W-1:0] w, output int acc);
    byte_in = w;
    byte_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        acc = edge_cnt;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: word %0h never accepted", w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int k);
    while (edge_cnt < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    byte_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy !== 1'b0 && t < 100);
    if (t >= 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: busy still %b", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lchk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    chk($sformatf("%s[%0d]", name, c), act, exp);
  endtask

  initial begin
    int a, b, x, a1, a2, a3;
    logic [31:0] pat;

    @(posedge clk);
    #1 checking = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", byte_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", serial_valid, 0);
    @(posedge clk);
    #1;

    // Single word 0xA5
    wait_idle();
    send(8'hA5, a);
    byte_valid = 1'b0;
    wait_cycle(a + 11);
    pat = 32'h0000_00A5;
    for (int i = 0; i < 8; i++) begin
      lchk("single_valid", a + 1 + i, lv[a + 1 + i], 1);
      lchk("single_bit", a + 1 + i, lb[a + 1 + i], pat[i]);
      lchk("single_done", a + 1 + i, ld[a + 1 + i], (i == 7));
    end
    lchk("single_end_valid", a + 9, lv[a + 9], 0);
    lchk("single_end_busy", a + 9, lbusy[a + 9], 0);

    // Back-to-back stream
    wait_idle();
    send(8'h34, a);
    send(8'h12, x);
    send(8'hCD, x);
    send(8'hAB, x);
    byte_valid = 1'b0;
    wait_cycle(a + 40);
    pat = 32'hABCD1234;
    for (int i = 0; i < 32; i++) begin
      lchk("stream_valid", a + 1 + i, lv[a + 1 + i], 1);
      lchk("stream_bit", a + 1 + i, lb[a + 1 + i], pat[i]);
      lchk("stream_done", a + 1 + i, ld[a + 1 + i], (i % 8 == 7));
    end
    lchk("stream_end_valid", a + 33, lv[a + 33], 0);

    // Backpressure with three words
    wait_idle();
    send(8'h11, a1);
    send(8'h22, a2);
    send(8'h33, a3);
    byte_valid = 1'b0;
    wait_cycle(a1 + 30);
    chk("bp_word2_accept", a2, a1 + 1);
    chk("bp_word3_accept", a3, a1 + 9);
    for (int c = a1 + 2; c <= a1 + 8; c++) lchk("bp_ready_low", c, lr[c], 0);
    lchk("bp_ready_high", a1 + 9, lr[a1 + 9], 1);
    for (int c = a1 + 1; c <= a1 + 24; c++) lchk("bp_valid", c, lv[c], 1);
    lchk("bp_end_valid", a1 + 25, lv[a1 + 25], 0);

    // Gap between words
    wait_idle();
    send(8'hFF, a);
    byte_valid = 1'b0;
    wait_cycle(a + 12);
    send(8'h01, b);
    byte_valid = 1'b0;
    wait_cycle(b + 10);
    lchk("gap_done", a + 8, ld[a + 8], 1);
    chk("gap_accept", b, a + 12);
    for (int c = a + 9; c <= a + 12; c++) lchk("gap_low", c, lv[c], 0);
    pat = 32'h0000_0001;
    for (int i = 0; i < 8; i++) begin
      lchk("gap_valid2", a + 13 + i, lv[a + 13 + i], 1);
      lchk("gap_bit2", a + 13 + i, lb[a + 13 + i], pat[i]);
    end

    // Reset in the middle of a word with a held word pending
    wait_idle();
    send(8'hC3, a);
    send(8'h3C, x);
    byte_valid = 1'b0;
    wait_cycle(a + 4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h81, b);
    byte_valid = 1'b0;
    wait_cycle(b + 10);
    pat = 32'h0000_00C3;
    for (int i = 0; i < 4; i++) lchk("rstmid_bit", a + 1 + i, lb[a + 1 + i], pat[i]);
    lchk("rstmid_ready_in_rst", a + 4, lr[a + 4], 0);
    lchk("rstmid_valid", a + 5, lv[a + 5], 0);
    lchk("rstmid_busy", a + 5, lbusy[a + 5], 0);
    lchk("rstmid_ready", a + 6, lr[a + 6], 1);
    chk("rstmid_accept", b, a + 5);
    pat = 32'h0000_0081;
    for (int i = 0; i < 8; i++) begin
      lchk("rstmid_valid2", b + 1 + i, lv[b + 1 + i], 1);
      lchk("rstmid_bit2", b + 1 + i, lb[b + 1 + i], pat[i]);
    end
    lchk("rstmid_end_valid", b + 9, lv[b + 9], 0);
    lchk("rstmid_end_busy", b + 9, lbusy[b + 9], 0);

    // Random traffic with occasional resets, checked by the model
    for (int n = 0; n < 3000; n++) begin
      byte_valid = ($urandom % 4) != 0;
      byte_in = W'($urandom);
      rst = ($urandom % 150) == 0;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    byte_valid = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
